// File: rtl/control_pipe_if.sv
// Bus between the decode/datapath side and control_pipe.
//   master: drives the ID-stage control bundles, register fields and mem_zero;
//           receives the staged bundles, destination registers and the
//           pc/ifid enables and branch/flush strobes.
//   slave : the mirror view, used by control_pipe.
interface control_pipe_if;
   logic       id_valid;
   logic [2:0] id_ex;
   logic [2:0] id_m;
   logic [1:0] id_wb;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic [4:0] id_rd;
   logic       mem_zero;

   logic [2:0] ex_ctrl;
   logic [4:0] ex_rt;
   logic [4:0] ex_dst;
   logic [2:0] mem_ctrl;
   logic [4:0] mem_dst;
   logic [1:0] wb_ctrl;
   logic [4:0] wb_dst;
   logic       pc_write;
   logic       ifid_write;
   logic       branch_taken;
   logic       flush;

   modport master (
      output id_valid, id_ex, id_m, id_wb, id_rs, id_rt, id_rd, mem_zero,
      input  ex_ctrl, ex_rt, ex_dst, mem_ctrl, mem_dst, wb_ctrl, wb_dst,
      input  pc_write, ifid_write, branch_taken, flush
   );

   modport slave (
      input  id_valid, id_ex, id_m, id_wb, id_rs, id_rt, id_rd, mem_zero,
      output ex_ctrl, ex_rt, ex_dst, mem_ctrl, mem_dst, wb_ctrl, wb_dst,
      output pc_write, ifid_write, branch_taken, flush
   );
endinterface

// File: rtl/control_pipe.sv
// Carries the decoded EX/M/WB control bundles through ID/EX, EX/MEM and
// MEM/WB, detects load-use hazards (one-cycle bubble), resolves branches in
// MEM (squashing ID and EX), and keeps saturating stall/flush counters.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus (slave) : ID-stage bundles in; staged bundles, dst fields,
//                 pc_write/ifid_write, branch_taken/flush out
//   stall_cnt   : saturating count of load-use stall cycles
//   flush_cnt   : saturating count of taken branches
module control_pipe #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   control_pipe_if.slave    bus,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef struct packed {
      logic [2:0] ex;
      logic [2:0] m;
      logic [1:0] wb;
      logic [4:0] rt;
      logic [4:0] rd;
   } idex_t;

   typedef struct packed {
      logic [2:0] m;
      logic [1:0] wb;
      logic [4:0] dst;
   } exmem_t;

   typedef struct packed {
      logic [1:0] wb;
      logic [4:0] dst;
   } memwb_t;

   idex_t            idex_q,  idex_d;
   exmem_t           exmem_q, exmem_d;
   memwb_t           memwb_q, memwb_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   idex_t            id_bundle;
   logic [4:0]       ex_dst_c;
   logic             stall_c;
   logic             taken_c;

   // Hazard detection, branch resolution and next-state of all stage registers
   always_comb begin
      id_bundle   = '0;
      idex_d      = '0;
      exmem_d     = '0;
      memwb_d     = '0;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;

      // An empty IF/ID slot enters the pipe exactly like a bubble
      if (bus.id_valid) begin
         id_bundle = '{ex: bus.id_ex, m: bus.id_m, wb: bus.id_wb,
                       rt: bus.id_rt, rd: bus.id_rd};
      end

      ex_dst_c = idex_q.ex[2] ? idex_q.rd : idex_q.rt;

      stall_c = idex_q.m[1] & bus.id_valid & (idex_q.rt != 5'd0) &
                ((idex_q.rt == bus.id_rs) | (idex_q.rt == bus.id_rt));
      taken_c = exmem_q.m[2] & bus.mem_zero;

      // MEM/WB always advances, even for a resolving branch
      memwb_d = '{wb: exmem_q.wb, dst: exmem_q.dst};

      if (taken_c) begin
         // Squash ID and EX; the flush overrides any concurrent stall
         idex_d  = '0;
         exmem_d = '0;
         if (flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end else begin
         exmem_d = '{m: idex_q.m, wb: idex_q.wb, dst: ex_dst_c};
         if (stall_c) begin
            idex_d = '0;
            if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_W'(1);
         end else begin
            idex_d = id_bundle;
         end
      end
   end

   // Stage and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idex_q      <= '0;
         exmem_q     <= '0;
         memwb_q     <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         idex_q      <= idex_d;
         exmem_q     <= exmem_d;
         memwb_q     <= memwb_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign bus.ex_ctrl      = idex_q.ex;
   assign bus.ex_rt        = idex_q.rt;
   assign bus.ex_dst       = ex_dst_c;
   assign bus.mem_ctrl     = exmem_q.m;
   assign bus.mem_dst      = exmem_q.dst;
   assign bus.wb_ctrl      = memwb_q.wb;
   assign bus.wb_dst       = memwb_q.dst;
   assign bus.pc_write     = ~stall_c | taken_c;
   assign bus.ifid_write   = ~stall_c | taken_c;
   assign bus.branch_taken = taken_c;
   assign bus.flush        = taken_c;
   assign stall_cnt        = stall_cnt_q;
   assign flush_cnt        = flush_cnt_q;

endmodule

// File: tb/tb_control_pipe.sv
module tb_control_pipe;

   localparam int unsigned CNT_W = 2;
   localparam logic [CNT_W-1:0] CMAX = '1;

   localparam logic [2:0] R_EX   = 3'b110;
   localparam logic [2:0] LW_EX  = 3'b001;
   localparam logic [2:0] LW_M   = 3'b010;
   localparam logic [1:0] LW_WB  = 2'b11;
   localparam logic [2:0] BEQ_EX = 3'b010;
   localparam logic [2:0] BEQ_M  = 3'b100;

   logic clk = 1'b0;
   logic rst_n;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   control_pipe_if bus ();

   control_pipe #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] ex_ctrl;
      logic [4:0] ex_rt;
      logic [4:0] ex_dst;
      logic [2:0] mem_ctrl;
      logic [4:0] mem_dst;
      logic [1:0] wb_ctrl;
      logic [4:0] wb_dst;
      logic [CNT_W-1:0] sc;
      logic [CNT_W-1:0] fc;
   } exp_t;

   exp_t exp_q[$];

   int checks = 0;
   int errors = 0;
   int pcw_low = 0;

   // Reference pipeline state
   logic [2:0] e_ex, e_m;  logic [1:0] e_wb; logic [4:0] e_rt, e_rd;
   logic [2:0] x_m;        logic [1:0] x_wb; logic [4:0] x_dst;
   logic [1:0] w_wb;       logic [4:0] w_dst;
   logic [CNT_W-1:0] m_sc, m_fc;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      e_ex = '0; e_m = '0; e_wb = '0; e_rt = '0; e_rd = '0;
      x_m = '0; x_wb = '0; x_dst = '0;
      w_wb = '0; w_dst = '0;
      m_sc = '0; m_fc = '0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".ex_ctrl"},  32'(bus.ex_ctrl), 0);
      chk({tag, ".ex_dst"},   32'(bus.ex_dst), 0);
      chk({tag, ".mem_ctrl"}, 32'(bus.mem_ctrl), 0);
      chk({tag, ".mem_dst"},  32'(bus.mem_dst), 0);
      chk({tag, ".wb_ctrl"},  32'(bus.wb_ctrl), 0);
      chk({tag, ".wb_dst"},   32'(bus.wb_dst), 0);
      chk({tag, ".flush"},    32'(bus.flush), 0);
      chk({tag, ".taken"},    32'(bus.branch_taken), 0);
      chk({tag, ".pc_write"}, 32'(bus.pc_write), 1);
      chk({tag, ".ifid_wr"},  32'(bus.ifid_write), 1);
      chk({tag, ".stall_cnt"}, 32'(stall_cnt), 0);
      chk({tag, ".flush_cnt"}, 32'(flush_cnt), 0);
   endtask

   // One clock of stimulus: drive on negedge, check combinational outputs,
   // push the expected registered state, pop and compare after the edge.
   task automatic cyc(input logic v, input logic [2:0] ex, input logic [2:0] m,
                      input logic [1:0] wb, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input logic z);
      logic stall, taken, pcw;
      logic [4:0] edst;
      exp_t e, o;
      @(negedge clk);
      bus.id_valid = v; bus.id_ex = ex; bus.id_m = m; bus.id_wb = wb;
      bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd; bus.mem_zero = z;
      #1;
      edst  = e_ex[2] ? e_rd : e_rt;
      stall = e_m[1] && v && (e_rt != 0) && (e_rt == rs || e_rt == rt);
      taken = x_m[2] && z;
      pcw   = taken || !stall;
      if (bus.pc_write === 1'b0) pcw_low++;
      chk("pc_write",     32'(bus.pc_write), 32'(pcw));
      chk("ifid_write",   32'(bus.ifid_write), 32'(pcw));
      chk("branch_taken", 32'(bus.branch_taken), 32'(taken));
      chk("flush",        32'(bus.flush), 32'(taken));

      // Advance the reference model
      w_wb = x_wb; w_dst = x_dst;
      if (taken) begin
         x_m = 0; x_wb = 0; x_dst = 0;
      end else begin
         x_m = e_m; x_wb = e_wb; x_dst = edst;
      end
      if (taken || stall || !v) begin
         e_ex = 0; e_m = 0; e_wb = 0; e_rt = 0; e_rd = 0;
      end else begin
         e_ex = ex; e_m = m; e_wb = wb; e_rt = rt; e_rd = rd;
      end
      if (taken && m_fc != CMAX) m_fc++;
      if (stall && !taken && m_sc != CMAX) m_sc++;

      e.ex_ctrl = e_ex; e.ex_rt = e_rt; e.ex_dst = e_ex[2] ? e_rd : e_rt;
      e.mem_ctrl = x_m; e.mem_dst = x_dst; e.wb_ctrl = w_wb; e.wb_dst = w_dst;
      e.sc = m_sc; e.fc = m_fc;
      exp_q.push_back(e);

      @(posedge clk); #1;
      o = exp_q.pop_front();
      chk("ex_ctrl",   32'(bus.ex_ctrl),  32'(o.ex_ctrl));
      chk("ex_rt",     32'(bus.ex_rt),    32'(o.ex_rt));
      chk("ex_dst",    32'(bus.ex_dst),   32'(o.ex_dst));
      chk("mem_ctrl",  32'(bus.mem_ctrl), 32'(o.mem_ctrl));
      chk("mem_dst",   32'(bus.mem_dst),  32'(o.mem_dst));
      chk("wb_ctrl",   32'(bus.wb_ctrl),  32'(o.wb_ctrl));
      chk("wb_dst",    32'(bus.wb_dst),   32'(o.wb_dst));
      chk("stall_cnt", 32'(stall_cnt),    32'(o.sc));
      chk("flush_cnt", 32'(flush_cnt),    32'(o.fc));
   endtask

   task automatic nop();
      cyc(1'b0, 3'b000, 3'b000, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0);
   endtask

   int p0;
   logic [CNT_W-1:0] sc_save;

   initial begin
      rst_n = 1'b0;
      bus.id_valid = 0; bus.id_ex = 0; bus.id_m = 0; bus.id_wb = 0;
      bus.id_rs = 0; bus.id_rt = 0; bus.id_rd = 0; bus.mem_zero = 0;
      model_reset();
      #1;
      chk_all_zero("reset");
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      // R-type flow
      p0 = pcw_low;
      cyc(1'b1, R_EX, 3'b000, 2'b10, 5'd1, 5'd3, 5'd5, 1'b0);
      chk("rtype.ex_ctrl", 32'(bus.ex_ctrl), 32'(3'b110));
      chk("rtype.ex_dst",  32'(bus.ex_dst), 5);
      nop();
      chk("rtype.mem_dst", 32'(bus.mem_dst), 5);
      nop();
      chk("rtype.wb_ctrl", 32'(bus.wb_ctrl), 32'(2'b10));
      chk("rtype.wb_dst",  32'(bus.wb_dst), 5);
      chk("rtype.pcw_low", 32'(pcw_low - p0), 0);

      // Load-use: lw rt=4 then rs=4 -> one stall cycle, then re-presented
      p0 = pcw_low;
      cyc(1'b1, LW_EX, LW_M, LW_WB, 5'd2, 5'd4, 5'd0, 1'b0);
      cyc(1'b1, R_EX, 3'b000, 2'b10, 5'd4, 5'd6, 5'd7, 1'b0);
      chk("lu.bubble_ex",  32'(bus.ex_ctrl), 0);
      chk("lu.lw_in_mem",  32'(bus.mem_ctrl), 32'(LW_M));
      chk("lu.stall_cnt",  32'(stall_cnt), 1);
      cyc(1'b1, R_EX, 3'b000, 2'b10, 5'd4, 5'd6, 5'd7, 1'b0);
      chk("lu.bubble_mem", 32'(bus.mem_ctrl), 0);
      chk("lu.pcw_low",    32'(pcw_low - p0), 1);
      nop(); nop();

      // Load into $0 followed by rs=0: no stall
      cyc(1'b1, LW_EX, LW_M, LW_WB, 5'd2, 5'd0, 5'd0, 1'b0);
      cyc(1'b1, R_EX, 3'b000, 2'b10, 5'd0, 5'd0, 5'd8, 1'b0);
      chk("r0.stall_cnt", 32'(stall_cnt), 1);
      chk("r0.ex_ctrl",   32'(bus.ex_ctrl), 32'(R_EX));
      nop(); nop();

      // Taken beq
      cyc(1'b1, BEQ_EX, BEQ_M, 2'b00, 5'd1, 5'd2, 5'd0, 1'b0);
      cyc(1'b1, R_EX, 3'b000, 2'b10, 5'd3, 5'd3, 5'd9, 1'b0);
      cyc(1'b1, R_EX, 3'b000, 2'b10, 5'd3, 5'd3, 5'd10, 1'b1);
      chk("tk.mem_ctrl",  32'(bus.mem_ctrl), 0);
      chk("tk.ex_ctrl",   32'(bus.ex_ctrl), 0);
      chk("tk.flush_cnt", 32'(flush_cnt), 1);
      nop(); nop();

      // Not-taken beq
      cyc(1'b1, BEQ_EX, BEQ_M, 2'b00, 5'd1, 5'd2, 5'd0, 1'b0);
      cyc(1'b1, R_EX, 3'b000, 2'b10, 5'd3, 5'd3, 5'd11, 1'b0);
      cyc(1'b1, R_EX, 3'b000, 2'b10, 5'd3, 5'd3, 5'd12, 1'b0);
      chk("nt.ex_dst",    32'(bus.ex_dst), 12);
      chk("nt.mem_dst",   32'(bus.mem_dst), 11);
      chk("nt.flush_cnt", 32'(flush_cnt), 1);
      nop(); nop();

      // Stall and taken branch in the same cycle
      sc_save = stall_cnt;
      cyc(1'b1, BEQ_EX, BEQ_M, 2'b00, 5'd1, 5'd2, 5'd0, 1'b0);
      cyc(1'b1, LW_EX, LW_M, LW_WB, 5'd2, 5'd7, 5'd0, 1'b0);
      p0 = pcw_low;
      cyc(1'b1, R_EX, 3'b000, 2'b10, 5'd7, 5'd1, 5'd13, 1'b1);
      chk("sim.pcw_low",   32'(pcw_low - p0), 0);
      chk("sim.stall_cnt", 32'(stall_cnt), 32'(sc_save));
      chk("sim.flush_cnt", 32'(flush_cnt), 2);
      chk("sim.mem_ctrl",  32'(bus.mem_ctrl), 0);

      // Asynchronous reset mid-stream
      cyc(1'b1, LW_EX, LW_M, LW_WB, 5'd2, 5'd9, 5'd0, 1'b0);
      cyc(1'b1, R_EX, 3'b000, 2'b10, 5'd9, 5'd1, 5'd14, 1'b0);
      @(negedge clk);
      bus.id_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk_all_zero("midrst");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // Stall counter saturation: 5 stalls with CNT_W=2
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, LW_EX, LW_M, LW_WB, 5'd2, 5'd9, 5'd0, 1'b0);
         cyc(1'b1, R_EX, 3'b000, 2'b10, 5'd1, 5'd9, 5'd15, 1'b0);
         cyc(1'b1, R_EX, 3'b000, 2'b10, 5'd1, 5'd9, 5'd15, 1'b0);
      end
      chk("sat.stall_cnt", 32'(stall_cnt), 3);

      // Flush counter saturation: 4 taken branches
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, BEQ_EX, BEQ_M, 2'b00, 5'd1, 5'd2, 5'd0, 1'b0);
         nop();
         cyc(1'b1, R_EX, 3'b000, 2'b10, 5'd3, 5'd3, 5'd16, 1'b1);
      end
      chk("sat.flush_cnt", 32'(flush_cnt), 3);
      nop(); nop(); nop();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
